// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with configurable pattern, length, overlap mode
// and hit limit. The match flag z is Mealy: it reflects the current x.
module seq_det_ctrl #(
    parameter  int unsigned PAT_W = 8,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_max_hits,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ov_q;
    logic [CNT_W-1:0] max_q;
    // Only the most recent PAT_W-1 bits are needed; the newest bit is x itself.
    logic [PAT_W-2:0] hist_q;
    logic [LEN_W-1:0] fill_q;
    logic [CNT_W-1:0] hit_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             len_ok;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic             fill_ok;
    logic             pat_eq;
    logic [LEN_W-1:0] fill_next;
    logic [CNT_W-1:0] hit_next;
    logic             limit_hit;
    logic             match;

    // Match evaluation on the history plus the bit currently on x.
    always_comb begin
        len_ok = (len_q != '0) && (len_q <= LEN_W'(PAT_W));
        window = {hist_q, x};
        mask   = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        fill_ok   = (({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q});
        pat_eq    = (((window ^ pat_q) & mask) == '0);
        fill_next = (fill_q < len_q) ? LEN_W'(fill_q + LEN_W'(1)) : fill_q;
        hit_next  = ((max_q == '0) && (hit_q == '1)) ? hit_q : CNT_W'(hit_q + CNT_W'(1));
        limit_hit = (max_q != '0) && (CNT_W'(hit_q + CNT_W'(1)) == max_q);
        match     = reset && (state_q == S_RUN) && x_valid && !abort && fill_ok && pat_eq;
    end

    assign z         = match;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hit_count = hit_q;
    assign cfg_err   = err_q;

    // Control FSM, configuration latch, history and hit counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ov_q    <= 1'b0;
            max_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            hit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_we) begin
                        // A config write wins over a simultaneous start.
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        ov_q  <= cfg_overlap;
                        max_q <= cfg_max_hits;
                        err_q <= 1'b0;
                    end else if (start) begin
                        if (len_ok) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            hit_q   <= '0;
                            hist_q  <= '0;
                            fill_q  <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (x_valid) begin
                        hist_q <= window[PAT_W-2:0];
                        if (match) begin
                            hit_q  <= hit_next;
                            fill_q <= ov_q ? fill_next : '0;
                            if (limit_hit) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            fill_q <= fill_next;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_seq_det_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_max_hits;
    logic             start;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             z;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_count;
    logic             cfg_err;

    always #5 clk = ~clk;

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_max_hits(cfg_max_hits),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .busy        (busy),
        .done        (done),
        .hit_count   (hit_count),
        .cfg_err     (cfg_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 done.
    int m_mode = 0;
    int m_pat = 0, m_len = 0, m_ov = 0, m_max = 0;
    int m_hits = 0, m_err = 0;
    int m_seg = 0;          // valid bits seen since start or since last non-overlap match
    bit m_bits[$];          // valid bits seen since start
    bit z_exp, z_obs;

    logic [10:0] stream = 11'b01101100110;

    function automatic bit model_z();
        int w;
        if (!reset || m_mode != 1 || !x_valid || abort) return 1'b0;
        if (m_seg + 1 < m_len) return 1'b0;
        if (m_bits.size() < m_len - 1) return 1'b0;
        w = 0;
        for (int i = m_len - 1; i >= 1; i--) w = (w << 1) | int'(m_bits[m_bits.size() - i]);
        w = (w << 1) | int'(x);
        return (w == (m_pat & ((1 << m_len) - 1)));
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_mode = 0; m_pat = 0; m_len = 0; m_ov = 0; m_max = 0;
            m_hits = 0; m_err = 0; m_seg = 0; m_bits.delete();
        end else begin
            case (m_mode)
                0: begin
                    if (cfg_we) begin
                        m_pat = 32'(cfg_pattern); m_len = 32'(cfg_len);
                        m_ov = 32'(cfg_overlap); m_max = 32'(cfg_max_hits); m_err = 0;
                    end else if (start) begin
                        if (m_len >= 1 && m_len <= int'(PAT_W)) begin
                            m_mode = 1; m_hits = 0; m_seg = 0; m_bits.delete();
                        end else m_err = 1;
                    end
                end
                1: begin
                    if (abort) m_mode = 0;
                    else if (x_valid) begin
                        m_bits.push_back(x);
                        if (m_bits.size() > 32) void'(m_bits.pop_front());
                        if (z_exp) begin
                            if (!(m_max == 0 && m_hits == 255)) m_hits++;
                            m_seg = (m_ov != 0) ? m_seg + 1 : 0;
                            if (m_max != 0 && m_hits == m_max) m_mode = 2;
                        end else m_seg++;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    // One clock: sample Mealy z mid-cycle, advance model, step past the edge.
    task automatic tick();
        #2;
        z_obs = z;
        z_exp = model_z();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        reset = 1'b1; cfg_we = 1'b0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] mx);
        idle_in();
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_max_hits = mx;
        tick();
        idle_in();
    endtask

    task automatic do_start();
        idle_in(); start = 1'b1; tick(); idle_in();
    endtask

    task automatic do_bit(input logic b, input logic ab);
        idle_in(); x = b; x_valid = 1'b1; abort = ab; tick(); idle_in();
    endtask

    task automatic do_gap();
        idle_in(); x = 1'($urandom); tick(); idle_in();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; x_valid = 1'b1; x = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (z_obs !== 1'b0) begin n_bad++; $display("FAIL reset_z: got %b want 0", z_obs); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (hit_count !== 8'd0) begin n_bad++; $display("FAIL reset_hits: got %0d want 0", hit_count); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cfg_err); end
        idle_in();
    endtask

    task automatic test_overlap();
        bit e;
        do_cfg(8'b0110, 4'd4, 1'b1, 8'd0);
        do_start();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ovl_busy_start: got %b want 1", busy); end
        for (int i = 1; i <= 11; i++) begin
            do_bit(stream[11-i], 1'b0);
            e = (i == 4 || i == 7 || i == 11);
            n_cmp++; if (z_obs !== e) begin n_bad++; $display("FAIL ovl_z bit%0d: got %b want %b", i, z_obs, e); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ovl_busy bit%0d: got %b want 1", i, busy); end
        end
        n_cmp++; if (hit_count !== 8'd3) begin n_bad++; $display("FAIL ovl_hits: got %0d want 3", hit_count); end
        do_bit(1'b0, 1'b1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovl_abort_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ovl_abort_done: got %b want 0", done); end
    endtask

    task automatic test_nonoverlap();
        bit e;
        do_cfg(8'b0110, 4'd4, 1'b0, 8'd0);
        do_start();
        for (int i = 1; i <= 11; i++) begin
            do_bit(stream[11-i], 1'b0);
            e = (i == 4 || i == 11);
            n_cmp++; if (z_obs !== e) begin n_bad++; $display("FAIL novl_z bit%0d: got %b want %b", i, z_obs, e); end
        end
        n_cmp++; if (hit_count !== 8'd2) begin n_bad++; $display("FAIL novl_hits: got %0d want 2", hit_count); end
        do_bit(1'b0, 1'b1);
    endtask

    task automatic test_hit_limit();
        bit e;
        do_cfg(8'b0110, 4'd4, 1'b1, 8'd2);
        do_start();
        for (int i = 1; i <= 11; i++) begin
            do_bit(stream[11-i], 1'b0);
            e = (i == 4 || i == 7);
            n_cmp++; if (z_obs !== e) begin n_bad++; $display("FAIL lim_z bit%0d: got %b want %b", i, z_obs, e); end
            e = (i == 7);
            n_cmp++; if (done !== e) begin n_bad++; $display("FAIL lim_done bit%0d: got %b want %b", i, done, e); end
            e = (i < 7);
            n_cmp++; if (busy !== e) begin n_bad++; $display("FAIL lim_busy bit%0d: got %b want %b", i, busy, e); end
        end
        n_cmp++; if (hit_count !== 8'd2) begin n_bad++; $display("FAIL lim_hits: got %0d want 2", hit_count); end
    endtask

    task automatic test_gaps();
        bit e;
        do_cfg(8'b0110, 4'd4, 1'b1, 8'd0);
        do_start();
        for (int i = 1; i <= 11; i++) begin
            for (int g = 0; g <= int'($urandom_range(0, 2)); g++) begin
                do_gap();
                n_cmp++; if (z_obs !== 1'b0) begin n_bad++; $display("FAIL gap_z before bit%0d: got %b want 0", i, z_obs); end
            end
            do_bit(stream[11-i], 1'b0);
            e = (i == 4 || i == 7 || i == 11);
            n_cmp++; if (z_obs !== e) begin n_bad++; $display("FAIL gap_z bit%0d: got %b want %b", i, z_obs, e); end
        end
        n_cmp++; if (hit_count !== 8'd3) begin n_bad++; $display("FAIL gap_hits: got %0d want 3", hit_count); end
        do_bit(1'b0, 1'b1);
    endtask

    task automatic test_illegal_abort();
        do_cfg(8'b0110, 4'd0, 1'b1, 8'd0);
        do_start();
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL ill_len0_err: got %b want 1", cfg_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ill_len0_busy: got %b want 0", busy); end
        do_cfg(8'b0110, 4'd9, 1'b1, 8'd0);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL ill_cfg_clear: got %b want 0", cfg_err); end
        do_start();
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL ill_len9_err: got %b want 1", cfg_err); end
        // Start together with a config write is ignored.
        idle_in();
        cfg_we = 1'b1; start = 1'b1; cfg_pattern = 8'b0110; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_max_hits = 8'd0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cfg_start_same_busy: got %b want 0", busy); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_start_same_err: got %b want 0", cfg_err); end
        do_start();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_start: got %b want 1", busy); end
        for (int i = 1; i <= 3; i++) do_bit(stream[11-i], 1'b0);
        do_bit(stream[7], 1'b1);
        n_cmp++; if (z_obs !== 1'b0) begin n_bad++; $display("FAIL abort_z: got %b want 0", z_obs); end
        n_cmp++; if (hit_count !== 8'd0) begin n_bad++; $display("FAIL abort_hits: got %0d want 0", hit_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
    endtask

    task automatic test_reset_midrun();
        do_cfg(8'b0110, 4'd4, 1'b1, 8'd0);
        do_start();
        for (int i = 1; i <= 4; i++) do_bit(stream[11-i], 1'b0);
        n_cmp++; if (z_obs !== 1'b1) begin n_bad++; $display("FAIL rmid_hit_z: got %b want 1", z_obs); end
        idle_in();
        reset = 1'b0; x_valid = 1'b1; x = 1'b1; start = 1'b1;
        tick();
        n_cmp++; if (z_obs !== 1'b0) begin n_bad++; $display("FAIL rmid_z: got %b want 0", z_obs); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b want 0", done); end
        n_cmp++; if (hit_count !== 8'd0) begin n_bad++; $display("FAIL rmid_hits: got %0d want 0", hit_count); end
        do_start();
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL rmid_nocfg_err: got %b want 1", cfg_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_nocfg_busy: got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        do_cfg(8'b1, 4'd1, 1'b0, 8'd0);
        do_start();
        for (int i = 0; i < 260; i++) do_bit(1'b1, 1'b0);
        n_cmp++; if (hit_count !== 8'd255) begin n_bad++; $display("FAIL sat_hits: got %0d want 255", hit_count); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sat_busy: got %b want 1", busy); end
        do_bit(1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 199) != 0);
            cfg_we       = ($urandom_range(0, 19) == 0);
            cfg_pattern  = 8'($urandom);
            cfg_len      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            cfg_overlap  = 1'($urandom);
            cfg_max_hits = 8'($urandom_range(0, 4));
            start        = ($urandom_range(0, 3) == 0);
            abort        = ($urandom_range(0, 39) == 0);
            x_valid      = ($urandom_range(0, 3) != 0);
            x            = 1'($urandom);
            tick();
            n_cmp++; if (z_obs !== z_exp) begin n_bad++; $display("FAIL rnd_z cyc%0d: got %b want %b", c, z_obs, z_exp); end
            n_cmp++; if (busy !== (m_mode == 1)) begin n_bad++; $display("FAIL rnd_busy cyc%0d: got %b want %b", c, busy, (m_mode == 1)); end
            n_cmp++; if (done !== (m_mode == 2)) begin n_bad++; $display("FAIL rnd_done cyc%0d: got %b want %b", c, done, (m_mode == 2)); end
            n_cmp++; if (hit_count !== 8'(m_hits)) begin n_bad++; $display("FAIL rnd_hits cyc%0d: got %0d want %0d", c, hit_count, m_hits); end
            n_cmp++; if (cfg_err !== 1'(m_err)) begin n_bad++; $display("FAIL rnd_err cyc%0d: got %b want %0d", c, cfg_err, m_err); end
        end
        idle_in();
    endtask

    initial begin
        idle_in();
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_max_hits = '0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_hit_limit();
        test_gaps();
        test_illegal_abort();
        test_reset_midrun();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
